// File: rtl/mem_io_responder.sv
// Byte-serial memory bus responder: block RAM plus memory-mapped UART TX/RX and halt register.
// Optional MEM_IO_STATS_EN adds read/write/IO access counters.
module mem_io_responder #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_halt,
  output logic [7:0]  exit_code,
  output logic        tx_overflow
`ifdef MEM_IO_STATS_EN
  ,
  output logic [31:0] stat_rd,
  output logic [31:0] stat_wr,
  output logic [31:0] stat_io
`endif
);

  localparam int unsigned PtrW = $clog2(TX_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt  = CntW'(TX_DEPTH);
  localparam logic [CntW-1:0] NearFull  = CntW'(TX_DEPTH - 2);
  localparam logic [17:0]     UartAddr  = 18'h3_0000;
  localparam logic [17:0]     HaltAddr  = 18'h3_0004;
  localparam logic [31:0]     RxPopAddr = 32'h0003_0000;

  logic              is_io;
  logic              sel_uart;
  logic              sel_halt;
  logic [ADDR_W-1:0] ram_addr;
  logic              push_req;
  logic              push_ok;
  logic              pop;

  logic [7:0]      ram_q [2**ADDR_W];
  logic [7:0]      fifo_mem_q [TX_DEPTH];

  logic [7:0]      mem_din_q,     mem_din_d;
  logic [31:0]     prev_a_q,      prev_a_d;
  logic            rx_ready_q,    rx_ready_d;
  logic            sim_halt_q,    sim_halt_d;
  logic [7:0]      exit_code_q,   exit_code_d;
  logic            tx_overflow_q, tx_overflow_d;
  logic [PtrW-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q,      rd_ptr_d;
  logic [CntW-1:0] count_q,       count_d;

  assign is_io    = (mem_a[17:16] == 2'b11);
  assign sel_uart = (mem_a[17:0] == UartAddr);
  assign sel_halt = (mem_a[17:0] == HaltAddr);
  assign ram_addr = mem_a[ADDR_W-1:0];

  assign tx_valid = (count_q != '0);
  assign pop      = tx_valid && tx_ready;
  assign push_req = mem_wr && sel_uart;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((count_q != DepthCnt) || pop);

  always_comb begin
    mem_din_d = 8'h00;
    if (!is_io) begin
      mem_din_d = ram_q[ram_addr];
    end else if (sel_uart && rx_valid) begin
      mem_din_d = rx_data;
    end

    prev_a_d = mem_a;
    // Pop only on entry to the RX address so an idling controller does not drain the UART.
    rx_ready_d = !mem_wr && rx_valid && (mem_a == RxPopAddr) && (prev_a_q != RxPopAddr);

    sim_halt_d  = sim_halt_q;
    exit_code_d = exit_code_q;
    if (mem_wr && sel_halt && !sim_halt_q) begin
      sim_halt_d  = 1'b1;
      exit_code_d = mem_dout;
    end

    tx_overflow_d = tx_overflow_q | (push_req && !push_ok);
    wr_ptr_d      = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d      = rd_ptr_q + PtrW'(pop);
    count_d       = count_q + CntW'(push_ok) - CntW'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din_q     <= 8'h00;
      prev_a_q      <= 32'hFFFF_FFFF;
      rx_ready_q    <= 1'b0;
      sim_halt_q    <= 1'b0;
      exit_code_q   <= 8'h00;
      tx_overflow_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < TX_DEPTH; i++) begin
        fifo_mem_q[i] <= 8'h00;
      end
    end else begin
      mem_din_q     <= mem_din_d;
      prev_a_q      <= prev_a_d;
      rx_ready_q    <= rx_ready_d;
      sim_halt_q    <= sim_halt_d;
      exit_code_q   <= exit_code_d;
      tx_overflow_q <= tx_overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (push_ok) begin
        fifo_mem_q[wr_ptr_q] <= mem_dout;
      end
    end
  end

  // RAM is not reset so program data survives a mid-run reset.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !is_io) begin
      ram_q[ram_addr] <= mem_dout;
    end
  end

  assign mem_din        = mem_din_q;
  assign tx_data        = fifo_mem_q[rd_ptr_q];
  assign io_buffer_full = (count_q >= NearFull);
  assign rx_ready       = rx_ready_q;
  assign sim_halt       = sim_halt_q;
  assign exit_code      = exit_code_q;
  assign tx_overflow    = tx_overflow_q;

`ifdef MEM_IO_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_io_q, stat_io_d;

  always_comb begin
    stat_rd_d = stat_rd_q + 32'(!is_io && !mem_wr && (mem_a != prev_a_q));
    stat_wr_d = stat_wr_q + 32'(!is_io && mem_wr);
    stat_io_d = stat_io_q + 32'(is_io);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
      stat_io_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
      stat_io_q <= stat_io_d;
    end
  end

  assign stat_rd = stat_rd_q;
  assign stat_wr = stat_wr_q;
  assign stat_io = stat_io_q;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read data and TX bytes are queued by the driver
// and checked by an independent monitor.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        sim_halt;
  logic [7:0]  exit_code;
  logic        tx_overflow;
`ifdef MEM_IO_STATS_EN
  logic [31:0] stat_rd;
  logic [31:0] stat_wr;
  logic [31:0] stat_io;
`endif

  always #5 clk_in = ~clk_in;

  mem_io_responder #(
    .ADDR_W  (17),
    .TX_DEPTH(16)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .mem_dout      (mem_dout),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .sim_halt      (sim_halt),
    .exit_code     (exit_code),
    .tx_overflow   (tx_overflow)
`ifdef MEM_IO_STATS_EN
    ,
    .stat_rd       (stat_rd),
    .stat_wr       (stat_wr),
    .stat_io       (stat_io)
`endif
  );

  typedef struct {
    logic [7:0] exp;
    string      name;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  int         n_cmp     = 0;
  int         n_err     = 0;
  int         rx_pulses = 0;
  int         cycles    = 0;
  logic       chk_now   = 1'b0;
  logic       due_q     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected output event, want none", name);
  endtask

  // One bus cycle; inputs change 1 time unit after the rising edge.
  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic chk, input logic [7:0] exp, input string name);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    chk_now  = chk;
    if (chk) rd_q.push_back('{exp, name});
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr_b(input logic [31:0] a, input logic [7:0] d);
    drive(a, 1'b1, d, 1'b0, 8'h00, "");
  endtask

  task automatic rd_c(input logic [31:0] a, input logic [7:0] exp, input string name);
    drive(a, 1'b0, 8'h00, 1'b1, exp, name);
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, "");
  endtask

  always @(posedge clk_in) begin
    due_q  <= chk_now;
    cycles <= cycles + 1;
    if (cycles > 3000) begin
      $display("FAIL timeout: got %0d cycles, want under 3000", cycles);
      $fatal(1, "bench timeout");
    end
  end

  always @(negedge clk_in) begin : monitor
    rd_exp_t e;
    if (due_q) begin
      if (rd_q.size() == 0) begin
        fail_now("mem_din_unexpected");
      end else begin
        e = rd_q.pop_front();
        check(e.name, {24'h0, mem_din}, {24'h0, e.exp});
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) fail_now("tx_unexpected");
      else check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
    end
    if (rx_ready) rx_pulses++;
  end

  initial begin
    rst_in   = 1'b1;
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;

    check("rst_mem_din", mem_din, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_sim_halt", sim_halt, 0);
    check("rst_exit_code", exit_code, 0);
    check("rst_tx_overflow", tx_overflow, 0);
    check("rst_io_buffer_full", io_buffer_full, 0);
    rst_in = 1'b0;
    idle();

    // RAM write then read, plus aliasing above 2^17
    wr_b(32'h0000_0010, 8'hA5);
    rd_c(32'h0000_0010, 8'hA5, "ram_rd_a5");
    rd_c(32'h0002_0010, 8'hA5, "ram_alias");
    for (int i = 0; i < 4; i++) wr_b(32'h100 + i, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) rd_c(32'h100 + i, 8'(8'h11 * (i + 1)), "ram_seq");
    idle();

    // TX FIFO fill, near-full flag, overflow, drain
    for (int i = 1; i <= 14; i++) begin
      wr_b(32'h0003_0000, 8'(i));
      tx_q.push_back(8'(i));
      if (i == 13) check("near_full_at_13", io_buffer_full, 0);
    end
    check("near_full_at_14", io_buffer_full, 1);
    for (int i = 15; i <= 16; i++) begin
      wr_b(32'h0003_0000, 8'(i));
      tx_q.push_back(8'(i));
    end
    check("no_overflow_at_16", tx_overflow, 0);
    wr_b(32'h0003_0000, 8'h99);
    check("overflow_at_17", tx_overflow, 1);
    tx_ready = 1'b1;
    repeat (16) idle();
    check("tx_drained_valid", tx_valid, 0);
    check("tx_drained_count", tx_q.size(), 0);
    check("tx_empty_not_full", io_buffer_full, 0);
    check("overflow_sticky", tx_overflow, 1);
    tx_ready = 1'b0;

    // RX pop on address entry only
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (3) rd_c(32'h0003_0000, 8'h5A, "rx_read");
    check("rx_one_pulse", rx_pulses, 1);
    rd_c(32'h0003_0001, 8'h00, "io_other_read");
    rd_c(32'h0003_0000, 8'h5A, "rx_read_again");
    idle();
    idle();
    check("rx_two_pulses", rx_pulses, 2);
    rx_valid = 1'b0;
    rd_c(32'h0003_0000, 8'h00, "rx_empty_read");
    idle();
    idle();
    check("rx_no_pop_when_empty", rx_pulses, 2);

    // Halt register: first write wins
    wr_b(32'h0003_0004, 8'h07);
    check("halt_set", sim_halt, 1);
    check("exit_code_first", exit_code, 8'h07);
    wr_b(32'h0003_0004, 8'h09);
    check("exit_code_kept", exit_code, 8'h07);
    rd_c(32'h0003_0004, 8'h00, "halt_read_zero");
    rd_c(32'h0000_0101, 8'h22, "ram_after_halt");
    idle();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) wr_b(32'h0003_0000, 8'(8'h50 + i));
    check("fifo_has_data", tx_valid, 1);
    rst_in = 1'b1;
    rd_c(32'h0000_0010, 8'h00, "rd_during_reset");
    rst_in = 1'b0;
    check("post_rst_tx_valid", tx_valid, 0);
    check("post_rst_sim_halt", sim_halt, 0);
    check("post_rst_exit_code", exit_code, 0);
    check("post_rst_overflow", tx_overflow, 0);
    rd_c(32'h0000_0010, 8'hA5, "ram_kept_after_reset");
    idle();
    tx_ready = 1'b1;
    idle();
    idle();
    check("post_rst_fifo_empty", tx_valid, 0);
    tx_ready = 1'b0;
    idle();
    check("rd_queue_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
